// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - core, network and memory bus signals of the data memory arbiter
interface data_memory_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_ack;
  logic              core_stall;

  logic              net_req;
  logic              net_we;
  logic [ADDR_W-1:0] net_addr;
  logic [DATA_W-1:0] net_wdata;
  logic [DATA_W-1:0] net_rdata;
  logic              net_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_ack, core_stall,
    input  net_req, net_we, net_addr, net_wdata,
    output net_rdata, net_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_ack, core_stall,
    output net_req, net_we, net_addr, net_wdata,
    input  net_rdata, net_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin arbiter sharing a single-port data memory between core and network
module data_memory_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_NET  = 1'b1;

  state_t            state_q, state_d;
  logic              winner_q, winner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] net_rdata_q, net_rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      winner_q     <= PORT_CORE;
      last_grant_q <= PORT_NET;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      core_rdata_q <= '0;
      net_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      core_rdata_q <= core_rdata_d;
      net_rdata_q  <= net_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    winner_d     = winner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    core_rdata_d = core_rdata_q;
    net_rdata_d  = net_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.core_req || bus.net_req) begin
          // On a tie the port that did not win last time is served
          if (bus.core_req && (!bus.net_req || last_grant_q == PORT_NET)) begin
            winner_d = PORT_CORE;
            we_d     = bus.core_we;
            addr_d   = bus.core_addr;
            wdata_d  = bus.core_wdata;
          end else begin
            winner_d = PORT_NET;
            we_d     = bus.net_we;
            addr_d   = bus.net_addr;
            wdata_d  = bus.net_wdata;
          end
          last_grant_d = winner_d;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 3'(MEM_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd1) begin
          if (!we_q) begin
            if (winner_q == PORT_CORE) core_rdata_d = bus.mem_rdata;
            else                       net_rdata_d  = bus.mem_rdata;
          end
          cnt_d   = 3'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latched request fields drive the memory so they stay stable from ISSUE through RESP
  assign bus.mem_en     = (state_q == ISSUE);
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;

  assign bus.core_ack   = (state_q == RESP) && (winner_q == PORT_CORE);
  assign bus.net_ack    = (state_q == RESP) && (winner_q == PORT_NET);
  assign bus.core_rdata = core_rdata_q;
  assign bus.net_rdata  = net_rdata_q;
  assign bus.core_stall = bus.core_req & ~bus.core_ack;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed bench for data_memory_arbiter at memory latencies 1 and 4
module tb_data_memory_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_v        [2];
  logic          core_req_v   [2];
  logic          core_we_v    [2];
  logic [15:0]   core_addr_v  [2];
  logic [15:0]   core_wdata_v [2];
  logic          net_req_v    [2];
  logic          net_we_v     [2];
  logic [15:0]   net_addr_v   [2];
  logic [15:0]   net_wdata_v  [2];
  logic          core_ack_o   [2];
  logic          core_stall_o [2];
  logic          net_ack_o    [2];
  logic          mem_en_o     [2];
  logic          mem_we_o     [2];
  logic [15:0]   core_rdata_o [2];
  logic [15:0]   net_rdata_o  [2];
  logic [15:0]   mem_addr_o   [2];
  logic [15:0]   mem_wdata_o  [2];

  // Instance 0 runs with MEM_LATENCY 1, instance 1 with MEM_LATENCY 4
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [15:0] mem  [1024];
    logic [15:0] pipe [4];
    logic        loaded = 1'b0;

    data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) u_dut (
      .clk (clk),
      .rst (rst_v[g]),
      .bus (bus.slave)
    );

    assign bus.core_req   = core_req_v[g];
    assign bus.core_we    = core_we_v[g];
    assign bus.core_addr  = core_addr_v[g];
    assign bus.core_wdata = core_wdata_v[g];
    assign bus.net_req    = net_req_v[g];
    assign bus.net_we     = net_we_v[g];
    assign bus.net_addr   = net_addr_v[g];
    assign bus.net_wdata  = net_wdata_v[g];
    assign bus.mem_rdata  = pipe[LAT-1];
    assign core_ack_o[g]   = bus.core_ack;
    assign core_stall_o[g] = bus.core_stall;
    assign net_ack_o[g]    = bus.net_ack;
    assign mem_en_o[g]     = bus.mem_en;
    assign mem_we_o[g]     = bus.mem_we;
    assign core_rdata_o[g] = bus.core_rdata;
    assign net_rdata_o[g]  = bus.net_rdata;
    assign mem_addr_o[g]   = bus.mem_addr;
    assign mem_wdata_o[g]  = bus.mem_wdata;

    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 1024; i++) mem[i] <= 16'(i) ^ 16'h5A00;
        mem[10'h040] <= 16'hBEEF;
        for (int i = 0; i < 4; i++) pipe[i] <= 16'h0000;
        loaded <= 1'b1;
      end else begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        pipe[0] <= bus.mem_en ? mem[bus.mem_addr[9:0]] : 16'hDEAD;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic access(input int d, input bit port, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, output int en_k, output int ack_k,
                        output logic [15:0] en_addr, output logic en_we, output logic [15:0] en_wdata,
                        output logic [15:0] rdata, output int stalls);
    en_k = -1; ack_k = -1; en_addr = '0; en_we = 1'b0; en_wdata = '0; rdata = '0; stalls = 0;
    @(posedge clk); #1;
    if (port == 1'b0) begin
      core_req_v[d] = 1'b1; core_we_v[d] = we; core_addr_v[d] = addr; core_wdata_v[d] = wdata;
    end else begin
      net_req_v[d] = 1'b1; net_we_v[d] = we; net_addr_v[d] = addr; net_wdata_v[d] = wdata;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_en_o[d] && en_k < 0) begin
        en_k = k; en_addr = mem_addr_o[d]; en_we = mem_we_o[d]; en_wdata = mem_wdata_o[d];
      end
      if (core_stall_o[d]) stalls++;
      if (port == 1'b0 ? core_ack_o[d] : net_ack_o[d]) begin
        ack_k = k;
        rdata = (port == 1'b0) ? core_rdata_o[d] : net_rdata_o[d];
        break;
      end
      if (k == 0) begin
        // Request fields change after the grant and must be ignored
        @(posedge clk); #1;
        core_addr_v[d] = ~core_addr_v[d]; core_wdata_v[d] = ~core_wdata_v[d]; core_we_v[d] = ~core_we_v[d];
        net_addr_v[d]  = ~net_addr_v[d];  net_wdata_v[d]  = ~net_wdata_v[d];  net_we_v[d]  = ~net_we_v[d];
      end
    end
    @(posedge clk); #1;
    core_req_v[d] = 1'b0;
    net_req_v[d]  = 1'b0;
  endtask

  typedef struct {
    int          d;
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_ack;
  } vec_t;

  vec_t vecs[10];

  initial begin : main
    int en_k, ack_k, stalls, acks, n_en, first, last_c, last_n, nc, nn, gap_c, gap_n, last_k;
    logic [15:0] en_addr, en_wdata, rdata, first_addr, first_wd, second_addr, net_rd, crd, nrd;
    logic en_we, first_we, c, n, cdone, ndone;
    int order[6];
    int ack_at[6];

    vecs[0] = '{0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3};
    vecs[1] = '{0, 1'b0, 1'b1, 16'h0050, 16'h1111, 16'hBEEF, 3};
    vecs[2] = '{0, 1'b0, 1'b0, 16'h0050, 16'h0000, 16'h1111, 3};
    vecs[3] = '{0, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3};
    vecs[4] = '{0, 1'b1, 1'b1, 16'h0060, 16'h2222, 16'hBEEF, 3};
    vecs[5] = '{0, 1'b0, 1'b0, 16'h0060, 16'h0000, 16'h2222, 3};
    vecs[6] = '{0, 1'b1, 1'b0, 16'h0050, 16'h0000, 16'h1111, 3};
    vecs[7] = '{1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 6};
    vecs[8] = '{1, 1'b1, 1'b1, 16'h0100, 16'h00AA, 16'h0000, 6};
    vecs[9] = '{1, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h00AA, 6};

    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b0;
      core_req_v[d] = 1'b0; core_we_v[d] = 1'b0; core_addr_v[d] = '0; core_wdata_v[d] = '0;
      net_req_v[d]  = 1'b0; net_we_v[d]  = 1'b0; net_addr_v[d]  = '0; net_wdata_v[d]  = '0;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_acks",   {30'd0, core_ack_o[0], net_ack_o[0]}, 32'd0);
    chk("rst_mem",    {mem_en_o[0], mem_we_o[0], mem_addr_o[0]}, 32'd0);
    chk("rst_wdata",  {16'd0, mem_wdata_o[0]}, 32'd0);
    chk("rst_rdata",  {core_rdata_o[0], net_rdata_o[0]}, 32'd0);
    chk("rst_acks_4", {30'd0, core_ack_o[1], net_ack_o[1]}, 32'd0);
    @(posedge clk); #1;
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;

    // Simultaneous requests straight after reset: core write vs net read
    for (int i = 0; i < 6; i++) begin order[i] = -1; ack_at[i] = -1; end
    acks = 0; n_en = 0; first_we = 1'b0; first_addr = '0; first_wd = '0; second_addr = '0; net_rd = '0;
    @(posedge clk); #1;
    core_req_v[0] = 1'b1; core_we_v[0] = 1'b1; core_addr_v[0] = 16'h0010; core_wdata_v[0] = 16'h1234;
    net_req_v[0]  = 1'b1; net_we_v[0]  = 1'b0; net_addr_v[0]  = 16'h0020;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (mem_en_o[0]) begin
        if (n_en == 0) begin first_we = mem_we_o[0]; first_addr = mem_addr_o[0]; first_wd = mem_wdata_o[0]; end
        if (n_en == 1) second_addr = mem_addr_o[0];
        n_en++;
      end
      if (core_ack_o[0] && acks < 6) begin order[acks] = 0; ack_at[acks] = k; acks++; end
      if (net_ack_o[0] && acks < 6) begin
        if (acks == 1) net_rd = net_rdata_o[0];
        order[acks] = 1; ack_at[acks] = k; acks++;
      end
      if (acks >= 6) break;
    end
    @(posedge clk); #1;
    core_req_v[0] = 1'b0; net_req_v[0] = 1'b0;
    chk("tie_first_we",    {31'd0, first_we}, 32'd1);
    chk("tie_first_addr",  {16'd0, first_addr}, 32'h0010);
    chk("tie_first_wdata", {16'd0, first_wd}, 32'h1234);
    chk("tie_second_addr", {16'd0, second_addr}, 32'h0020);
    for (int i = 0; i < 6; i++) chk($sformatf("tie_order_%0d", i), order[i], i % 2);
    chk("tie_first_ack", ack_at[0], 3);
    chk("tie_sixth_ack", ack_at[5], 23);
    chk("tie_net_rdata", {16'd0, net_rd}, 32'h5A20);

    for (int v = 0; v < 10; v++) begin
      access(vecs[v].d, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata,
             en_k, ack_k, en_addr, en_we, en_wdata, rdata, stalls);
      chk($sformatf("v%0d_ack_lat", v), ack_k, vecs[v].exp_ack);
      chk($sformatf("v%0d_en_lat", v), en_k, 1);
      chk($sformatf("v%0d_mem_addr", v), {16'd0, en_addr}, {16'd0, vecs[v].addr});
      chk($sformatf("v%0d_mem_we", v), {31'd0, en_we}, {31'd0, vecs[v].we});
      chk($sformatf("v%0d_rdata", v), {16'd0, rdata}, {16'd0, vecs[v].exp_rdata});
      chk($sformatf("v%0d_stalls", v), stalls, vecs[v].port ? 0 : vecs[v].exp_ack);
      if (vecs[v].we) chk($sformatf("v%0d_mem_wdata", v), {16'd0, en_wdata}, {16'd0, vecs[v].wdata});
    end
    chk("lat4_core_rdata_kept", {16'd0, core_rdata_o[1]}, 32'hBEEF);

    // Core drops its request during WAIT; the access must still complete
    @(posedge clk); #1;
    core_req_v[0] = 1'b1; core_we_v[0] = 1'b0; core_addr_v[0] = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    chk("drop_issue", {31'd0, mem_en_o[0]}, 32'd1);
    @(posedge clk); #1;
    core_req_v[0] = 1'b0;
    acks = 0; ack_k = -1; n_en = 0;
    for (int k = 2; k < 12; k++) begin
      @(negedge clk);
      if (core_ack_o[0]) begin acks++; ack_k = k; end
      if (mem_en_o[0]) n_en++;
    end
    chk("drop_ack_count", acks, 1);
    chk("drop_ack_cycle", ack_k, 3);
    chk("drop_no_regrant", n_en, 0);
    chk("drop_rdata", {16'd0, core_rdata_o[0]}, 32'hBEEF);

    // Reset asserted in the middle of a latency-4 WAIT
    @(posedge clk); #1;
    core_req_v[1] = 1'b1; core_we_v[1] = 1'b0; core_addr_v[1] = 16'h0040;
    repeat (3) @(posedge clk);
    #3;
    rst_v[1] = 1'b0;
    core_req_v[1] = 1'b0;
    #1;
    chk("mid_rst_mem",   {mem_en_o[1], mem_we_o[1], mem_addr_o[1]}, 32'd0);
    chk("mid_rst_wdata", {16'd0, mem_wdata_o[1]}, 32'd0);
    chk("mid_rst_acks",  {30'd0, core_ack_o[1], net_ack_o[1]}, 32'd0);
    chk("mid_rst_rdata", {core_rdata_o[1], net_rdata_o[1]}, 32'd0);
    acks = 0; n_en = 0;
    repeat (2) begin
      @(negedge clk);
      if (core_ack_o[1] || net_ack_o[1]) acks++;
    end
    @(posedge clk); #1;
    rst_v[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (core_ack_o[1] || net_ack_o[1]) acks++;
      if (mem_en_o[1]) n_en++;
    end
    chk("post_rst_no_ack", acks, 0);
    chk("post_rst_no_access", n_en, 0);

    @(posedge clk); #1;
    core_req_v[1] = 1'b1; core_we_v[1] = 1'b0; core_addr_v[1] = 16'h0040;
    net_req_v[1]  = 1'b1; net_we_v[1]  = 1'b0; net_addr_v[1]  = 16'h0100;
    first = -1; cdone = 1'b0; ndone = 1'b0; crd = '0; nrd = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      c = core_ack_o[1]; n = net_ack_o[1];
      if (c && !cdone) begin cdone = 1'b1; if (first < 0) first = 0; crd = core_rdata_o[1]; end
      if (n && !ndone) begin ndone = 1'b1; if (first < 0) first = 1; nrd = net_rdata_o[1]; end
      @(posedge clk); #1;
      if (c) core_req_v[1] = 1'b0;
      if (n) net_req_v[1]  = 1'b0;
      if (cdone && ndone) break;
    end
    core_req_v[1] = 1'b0; net_req_v[1] = 1'b0;
    chk("post_rst_first_core", first, 0);
    chk("post_rst_both_done", {30'd0, cdone, ndone}, 32'd3);
    chk("post_rst_core_rdata", {16'd0, crd}, 32'hBEEF);
    chk("post_rst_net_rdata", {16'd0, nrd}, 32'h00AA);

    // Continuous requests from both ports for 20 accesses at latency 1
    @(posedge clk); #1;
    core_req_v[0] = 1'b1; core_we_v[0] = 1'b0; core_addr_v[0] = 16'h0040;
    net_req_v[0]  = 1'b1; net_we_v[0]  = 1'b0; net_addr_v[0]  = 16'h0050;
    nc = 0; nn = 0; last_c = -1; last_n = -1; gap_c = 0; gap_n = 0; last_k = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (core_ack_o[0]) begin
        if (last_c >= 0 && k - last_c > gap_c) gap_c = k - last_c;
        last_c = k; nc++;
      end
      if (net_ack_o[0]) begin
        if (last_n >= 0 && k - last_n > gap_n) gap_n = k - last_n;
        last_n = k; nn++;
      end
      if (nc + nn >= 20) begin last_k = k; break; end
    end
    @(posedge clk); #1;
    core_req_v[0] = 1'b0; net_req_v[0] = 1'b0;
    chk("cont_core_acks", nc, 10);
    chk("cont_net_acks", nn, 10);
    chk("cont_core_gap_ok", {31'd0, gap_c <= 8}, 32'd1);
    chk("cont_net_gap_ok", {31'd0, gap_n <= 8}, 32'd1);
    chk("cont_last_ack", last_k, 79);
    chk("cont_net_rdata", {16'd0, net_rdata_o[0]}, 32'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end
endmodule
